cp_frame_serializer: RTL and testbench

// - Parallel-to-serial stage directly downstream of the cyclic-prefix inserter in the OFDM baseband TX.
// - Captures one CP-extended frame of FRAME_LEN signed samples and streams it one sample per cycle on a valid/ready interface toward the DAC/upconverter.
// - Two-deep frame buffer (active + shadow) gives gap-free back-to-back frames.

---
 rtl/cp_frame_serializer.sv | 184 ++++++++++++++++++
 tb/tb_cp_frame_serializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_frame_serializer.sv
// -----------------------------------------------------------------------------
// cp_frame_serializer
// Parallel-to-serial stage that sits after the cyclic-prefix inserter in the
// OFDM baseband transmitter. A complete CP-extended frame of FRAME_LEN signed
// samples is captured in one cycle and streamed out one sample per cycle on a
// valid/ready interface. An active buffer plus a shadow buffer let the next
// frame be parked while the current one drains, so back-to-back frames leave
// without a gap.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous, active-low reset
//   frame_in     in   FRAME_LEN x DATA_WIDTH signed frame, element 0 first
//   frame_valid  in   frame_in holds a new frame
//   frame_ready  out  a frame can be accepted this cycle (shadow is empty)
//   m_data       out  serial sample
//   m_valid      out  m_data is valid
//   m_ready      in   downstream accepts m_data
//   m_last       out  m_data is the final sample of its frame
//   m_index      out  position of m_data within its frame
//   frame_count  out  completed frames (last sample handshaken), wraps
// -----------------------------------------------------------------------------
module cp_frame_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [DATA_WIDTH-1:0]        frame_in [FRAME_LEN],
    input  logic                                frame_valid,
    output logic                                frame_ready,
    output logic        [DATA_WIDTH-1:0]        m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic                                m_last,
    output logic        [$clog2(FRAME_LEN)-1:0] m_index,
    output logic        [CNT_WIDTH-1:0]         frame_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // ST_IDLE: active empty; ST_STREAM: active full, shadow empty;
    // ST_FULL: both buffers hold a frame.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    state_t                        state_r;
    logic signed [DATA_WIDTH-1:0]  active_r [FRAME_LEN];
    logic signed [DATA_WIDTH-1:0]  shadow_r [FRAME_LEN];
    logic        [IDX_W-1:0]       idx_r;
    logic        [DATA_WIDTH-1:0]  m_data_r;
    logic                          m_valid_r;
    logic                          m_last_r;
    logic                          frame_ready_r;
    logic        [CNT_WIDTH-1:0]   count_r;

    logic                          accept_s;
    logic                          hs_s;
    logic                          last_hs_s;
    logic        [IDX_W-1:0]       idx_nx_s;

    // frame_ready comes only from a register, so accept has no
    // combinational dependency from frame_valid to frame_ready.
    assign accept_s  = frame_valid & frame_ready_r;
    assign hs_s      = m_valid_r & m_ready;
    assign last_hs_s = hs_s & m_last_r;
    assign idx_nx_s  = idx_r + IDX_ONE;

    assign frame_ready = frame_ready_r;
    assign m_data      = m_data_r;
    assign m_valid     = m_valid_r;
    assign m_last      = m_last_r;
    assign m_index     = idx_r;
    assign frame_count = count_r;

    // Frame buffers, serializer FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            for (int i = 0; i < FRAME_LEN; i++) begin
                active_r[i] <= DATA_ZERO;
                shadow_r[i] <= DATA_ZERO;
            end
            idx_r         <= IDX_ZERO;
            m_data_r      <= DATA_ZERO;
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
            frame_ready_r <= 1'b1;
            count_r       <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // FRAME_LEN >= 2, so sample 0 is never the last one.
                        active_r  <= frame_in;
                        idx_r     <= IDX_ZERO;
                        m_data_r  <= frame_in[0];
                        m_last_r  <= 1'b0;
                        m_valid_r <= 1'b1;
                        state_r   <= ST_STREAM;
                    end else begin
                        m_valid_r <= 1'b0;
                    end
                end

                ST_STREAM: begin
                    if (last_hs_s) begin
                        count_r <= count_r + CNT_ONE;
                        idx_r   <= IDX_ZERO;
                        if (accept_s) begin
                            // New frame goes straight to active: no bubble.
                            active_r  <= frame_in;
                            m_data_r  <= frame_in[0];
                            m_last_r  <= 1'b0;
                            m_valid_r <= 1'b1;
                            state_r   <= ST_STREAM;
                        end else begin
                            // m_data keeps the final sample while idle.
                            m_last_r  <= 1'b0;
                            m_valid_r <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                    end else begin
                        if (hs_s) begin
                            idx_r    <= idx_nx_s;
                            m_data_r <= active_r[idx_nx_s];
                            m_last_r <= (idx_nx_s == IDX_LAST);
                        end else begin
                            idx_r    <= idx_r;
                        end
                        if (accept_s) begin
                            shadow_r      <= frame_in;
                            frame_ready_r <= 1'b0;
                            state_r       <= ST_FULL;
                        end else begin
                            state_r       <= ST_STREAM;
                        end
                    end
                end

                ST_FULL: begin
                    // frame_ready_r is low here, so frame_valid is ignored
                    // even in the cycle of the last-sample handshake.
                    if (last_hs_s) begin
                        count_r       <= count_r + CNT_ONE;
                        active_r      <= shadow_r;
                        idx_r         <= IDX_ZERO;
                        m_data_r      <= shadow_r[0];
                        m_last_r      <= 1'b0;
                        m_valid_r     <= 1'b1;
                        frame_ready_r <= 1'b1;
                        state_r       <= ST_STREAM;
                    end else if (hs_s) begin
                        idx_r    <= idx_nx_s;
                        m_data_r <= active_r[idx_nx_s];
                        m_last_r <= (idx_nx_s == IDX_LAST);
                    end else begin
                        idx_r    <= idx_r;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    idx_r         <= IDX_ZERO;
                    m_valid_r     <= 1'b0;
                    m_last_r      <= 1'b0;
                    frame_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp_frame_serializer.sv
module tb_cp_frame_serializer;

    localparam int DW = 32;
    localparam int L  = 10;
    localparam int CW = 16;
    localparam int IW = $clog2(L);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [DW-1:0] frame_in [L];
    logic                 frame_valid = 1'b0;
    logic                 m_ready     = 1'b0;

    logic          frame_ready, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_index;
    logic [CW-1:0] frame_count;

    logic          frame_ready2, m_valid2, m_last2;
    logic [DW-1:0] m_data2;
    logic [IW-1:0] m_index2;
    logic [1:0]    frame_count2;

    cp_frame_serializer #(.DATA_WIDTH(DW), .FRAME_LEN(L), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .m_index(m_index),
        .frame_count(frame_count)
    );

    // Narrow-counter copy driven by the same stimulus, used for wrap checks.
    cp_frame_serializer #(.DATA_WIDTH(DW), .FRAME_LEN(L), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready2), .m_data(m_data2), .m_valid(m_valid2),
        .m_ready(m_ready), .m_last(m_last2), .m_index(m_index2),
        .frame_count(frame_count2)
    );

    // Reference model: every accepted sample queued in output order.
    logic signed [DW-1:0] q [$];
    int                   pos;
    int                   exp_cnt;
    logic [DW-1:0]        ld;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        q.delete();
        pos     = 0;
        exp_cnt = 0;
        ld      = '0;
    endtask

    // Drive one clock of stimulus and advance the model (no comparisons).
    task automatic cycle(input logic fv, input logic mr);
        logic hs, acc;
        frame_valid = fv;
        m_ready     = mr;
        hs  = (q.size() > 0) && mr;
        acc = fv && (q.size() <= L);
        @(posedge clk);
        if (hs) begin
            void'(q.pop_front());
            pos = pos + 1;
            if (pos == L) begin
                pos     = 0;
                exp_cnt = exp_cnt + 1;
            end
        end
        if (acc) begin
            for (int i = 0; i < L; i++) q.push_back(frame_in[i]);
        end
        if (q.size() > 0) ld = q[0];
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; frame_valid = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < L; i++) frame_in[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({m_valid, m_last, m_index, m_data, frame_count, frame_ready} !== {1'b0, 1'b0, IW'(0), DW'(0), CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b last=%0b idx=%0d data=%0d cnt=%0d ready=%0b, required 0 0 0 0 0 1",
                     m_valid, m_last, m_index, m_data, frame_count, frame_ready);
        end
        rst = 1'b1;
        model_reset();
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_single();
        logic signed [DW-1:0] exp [L];
        for (int i = 0; i < L; i++) begin
            exp[i]      = DW'((6 + i) % 8);
            frame_in[i] = exp[i];
        end
        cycle(1'b1, 1'b1);
        for (int k = 0; k < L; k++) begin
            frame_in[0] = 32'sd555;
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp[k] || m_last !== (k == L - 1) || m_index !== IW'(k)) begin
                n_fail++;
                $display("FAIL single_k%0d: valid=%0b data=%0d last=%0b idx=%0d, required 1 %0d %0b %0d",
                         k, m_valid, $signed(m_data), m_last, m_index, exp[k], k == L - 1, k);
            end
            cycle(1'b0, 1'b1);
        end
        n_checks++;
        if (m_valid !== 1'b0 || frame_count !== CW'(1) || m_data !== DW'(7)) begin
            n_fail++;
            $display("FAIL single_end: valid=%0b cnt=%0d data=%0d, required 0 1 7", m_valid, frame_count, m_data);
        end
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   c = 0;
        for (int i = 0; i < L; i++) frame_in[i] = DW'(-20 + 3 * i);
        cycle(1'b1, 1'b0);
        while (q.size() > 0 && c < 60) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== ld || m_index !== IW'(pos) || m_last !== (pos == L - 1)) begin
                n_fail++;
                $display("FAIL backpressure_c%0d: valid=%0b data=%0d idx=%0d last=%0b, required 1 %0d %0d %0b",
                         c, m_valid, $signed(m_data), m_index, m_last, $signed(ld), pos, pos == L - 1);
            end
            cycle(1'b0, pat[c % 4]);
            c++;
        end
        n_checks++;
        if (q.size() != 0 || m_valid !== 1'b0 || frame_count !== CW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL backpressure_drain: left=%0d valid=%0b cnt=%0d, required 0 0 %0d",
                     q.size(), m_valid, frame_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int base_cnt = exp_cnt;
        for (int i = 0; i < L; i++) frame_in[i] = DW'(i);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < L; i++) frame_in[i] = DW'(100 + i);
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 2 * L - 1; k++) begin
            for (int i = 0; i < L; i++) frame_in[i] = DW'($urandom);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== ld || frame_ready !== (q.size() <= L)) begin
                n_fail++;
                $display("FAIL b2b_k%0d: valid=%0b data=%0d ready=%0b, required 1 %0d %0b",
                         k, m_valid, $signed(m_data), frame_ready, $signed(ld), q.size() <= L);
            end
            if (k == L - 1) begin
                n_checks++;
                if (m_data !== DW'(100)) begin
                    n_fail++;
                    $display("FAIL b2b_gap: data=%0d, required 100", m_data);
                end
            end
            cycle(1'b0, 1'b1);
        end
        n_checks++;
        if (m_valid !== 1'b0 || frame_count !== CW'(base_cnt + 2)) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%0b cnt=%0d, required 0 %0d", m_valid, frame_count, base_cnt + 2);
        end
    endtask

    task automatic test_simultaneous();
        int k = 0;
        for (int i = 0; i < L; i++) frame_in[i] = DW'(50 + i);
        cycle(1'b1, 1'b1);
        while (pos != L - 1 && k < 3 * L) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        for (int i = 0; i < L; i++) frame_in[i] = DW'(-1 - i);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < L; i++) frame_in[i] = '0;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== DW'(-1) || m_index !== IW'(0)) begin
            n_fail++;
            $display("FAIL simultaneous: valid=%0b data=%0d idx=%0d, required 1 -1 0",
                     m_valid, $signed(m_data), m_index);
        end
        for (int j = 0; j < L; j++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(-1 - j)) begin
                n_fail++;
                $display("FAIL simult_j%0d: valid=%0b data=%0d, required 1 %0d", j, m_valid, $signed(m_data), -1 - j);
            end
            cycle(1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < L; i++) frame_in[i] = DW'(200 + i);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_last, m_index, m_data, frame_count, frame_ready} !== {1'b0, 1'b0, IW'(0), DW'(0), CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b last=%0b idx=%0d data=%0d cnt=%0d ready=%0b, required 0 0 0 0 0 1",
                     m_valid, m_last, m_index, m_data, frame_count, frame_ready);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        for (int k = 0; k < L + 2; k++) begin
            cycle(1'b0, 1'b1);
            n_checks++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_k%0d: valid=%0b, required 0", k, m_valid);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < L; i++) frame_in[i] = DW'($urandom);
            cycle(1'b1, 1'b1);
            repeat (L) cycle(1'b0, 1'b1);
            n_checks++;
            if (frame_count2 !== seq[f] || frame_count !== CW'(f + 1)) begin
                n_fail++;
                $display("FAIL wrap_f%0d: cnt2=%0d cnt=%0d, required %0d %0d",
                         f, frame_count2, frame_count, seq[f], f + 1);
            end
        end
    endtask

    task automatic test_random();
        int k = 0;
        for (int c = 0; c < 600; c++) begin
            n_checks++;
            if (m_valid !== (q.size() > 0) || m_data !== ld || m_index !== IW'(pos) ||
                m_last !== ((q.size() > 0) && (pos == L - 1)) || frame_ready !== (q.size() <= L) ||
                frame_count !== CW'(exp_cnt) || frame_count2 !== 2'(exp_cnt) || m_data2 !== ld) begin
                n_fail++;
                $display("FAIL random_c%0d: valid=%0b data=%0d idx=%0d last=%0b ready=%0b cnt=%0d cnt2=%0d, required %0b %0d %0d %0b %0b %0d %0d",
                         c, m_valid, $signed(m_data), m_index, m_last, frame_ready, frame_count, frame_count2,
                         q.size() > 0, $signed(ld), pos, (q.size() > 0) && (pos == L - 1), q.size() <= L,
                         exp_cnt % (1 << CW), exp_cnt % 4);
            end
            for (int i = 0; i < L; i++) frame_in[i] = DW'($urandom);
            cycle(($urandom % 3) != 0, ($urandom % 4) != 0);
        end
        while (q.size() > 0 && k < 4 * L) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        n_checks++;
        if (q.size() != 0 || m_valid !== 1'b0 || frame_count !== CW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL random_drain: left=%0d valid=%0b cnt=%0d, required 0 0 %0d",
                     q.size(), m_valid, frame_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
